execute_stage_pipe: RTL and testbench

//  Parametrised, registered execute stage between decode and memory. Computes ALU result,

---
 rtl/execute_stage_pipe_pkg.sv | 28 ++
 rtl/execute_stage_pipe_if.sv | 39 +++
 rtl/execute_stage_pipe_mult.sv | 84 ++++++++
 rtl/execute_stage_pipe.sv | 141 ++++++++++++++
 tb/tb_execute_stage_pipe.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pipe_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions, jump kinds, FSM states.
package execute_stage_pipe_pkg;

    // Jumps write the link value (pc_next) as their result, so LINK needs no opcode of its own.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,  ALU_ANDN = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,  ALU_ROL  = 4'd9,  ALU_ROR  = 4'd10, ALU_SEQ  = 4'd11,
        ALU_SLT  = 4'd12, ALU_SLE  = 4'd13, ALU_PASS = 4'd14, ALU_MUL  = 4'd15
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0, BR_EQZ = 3'd1, BR_NEZ = 3'd2, BR_LTZ = 3'd3, BR_GEZ = 3'd4
    } br_cond_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0, JMP_REL = 2'd1, JMP_REG = 2'd2
    } jmp_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2
    } ex_state_t;

    function automatic logic is_jump(input logic [1:0] kind);
        return (kind == JMP_REL) || (kind == JMP_REG);
    endfunction

endpackage

// File: rtl/execute_stage_pipe_if.sv
// Decode-side and memory-side handshake bundle of the execute stage.
interface execute_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc_next;
    logic [3:0]        id_alu_op;
    logic              id_src_imm;
    logic [2:0]        id_br_cond;
    logic [1:0]        id_jmp_kind;
    logic              id_wr_en;
    logic [REG_W-1:0]  id_wr_reg;
    logic              mem_ready;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_store;
    logic              ex_wr_en;
    logic [REG_W-1:0]  ex_wr_reg;
    logic              ex_redirect;
    logic [DATA_W-1:0] ex_target;

    modport master (
        output flush, id_valid, id_a, id_b, id_imm, id_pc_next, id_alu_op, id_src_imm,
               id_br_cond, id_jmp_kind, id_wr_en, id_wr_reg, mem_ready,
        input  id_ready, ex_valid, ex_result, ex_store, ex_wr_en, ex_wr_reg, ex_redirect, ex_target
    );

    modport slave (
        input  flush, id_valid, id_a, id_b, id_imm, id_pc_next, id_alu_op, id_src_imm,
               id_br_cond, id_jmp_kind, id_wr_en, id_wr_reg, mem_ready,
        output id_ready, ex_valid, ex_result, ex_store, ex_wr_en, ex_wr_reg, ex_redirect, ex_target
    );
endinterface

// File: rtl/execute_stage_pipe_mult.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle (IDLE/BUSY/DONE).
module execute_stage_pipe_mult
    import execute_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              hold,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int MUL_CYC = DATA_W / MUL_STEP;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

    ex_state_t         state_r, state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] mcand_r, mplier_r, acc_r, partial_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // FSM next state; DONE lingers while the output latch is still held downstream
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = start ? ST_BUSY : ST_IDLE;
                ST_BUSY: state_s = (cnt_r == '0) ? ST_DONE : ST_BUSY;
                ST_DONE: state_s = hold ? ST_DONE : ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_r != ST_IDLE);
        done = (state_r == ST_DONE) & ~hold & ~clear;
    end

    // Partial product for the MUL_STEP low multiplier bits
    always_comb begin
        partial_s = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            partial_s = partial_s + (mplier_r[i] ? (mcand_r << i) : '0);
        end
    end

    // Operand capture and shift-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if ((state_r == ST_IDLE) && start && !clear) begin
            cnt_r    <= CNT_LAST;
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
        end else if ((state_r == ST_BUSY) && !clear) begin
            cnt_r    <= cnt_r - CNT_W'(1);
            mcand_r  <= mcand_r << MUL_STEP;
            mplier_r <= mplier_r >> MUL_STEP;
            acc_r    <= acc_r + partial_s;
        end
    end

    assign product = acc_r;

endmodule

// File: rtl/execute_stage_pipe.sv
// Registered execute stage: ALU, branch/jump resolution, redirect and the EX/MEM output latch.
module execute_stage_pipe
    import execute_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 3,
    parameter int MUL_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    execute_stage_pipe_if.slave  bus
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W:0] SH_FULL = DATA_W[SH_W:0];

    logic [DATA_W-1:0] op2_s, alu_s, result_s, target_s, product_s;
    logic [SH_W-1:0]   sh_s;
    logic [SH_W:0]     inv_sh_s;
    logic              jump_s, taken_s, redir_s, is_mul_s, accept_s, hold_s;
    logic              mul_busy_s, mul_done_s;

    logic              ex_valid_r, ex_wr_en_r, ex_redirect_r, pend_wr_en_r;
    logic [DATA_W-1:0] ex_result_r, ex_store_r, ex_target_r, pend_store_r;
    logic [REG_W-1:0]  ex_wr_reg_r, pend_wr_reg_r;

    // ALU; rotates combine two opposite shifts so a zero amount stays exact
    always_comb begin
        op2_s    = bus.id_src_imm ? bus.id_imm : bus.id_b;
        sh_s     = op2_s[SH_W-1:0];
        inv_sh_s = SH_FULL - {1'b0, sh_s};
        alu_s    = '0;
        case (bus.id_alu_op)
            ALU_ADD:  alu_s = bus.id_a + op2_s;
            ALU_SUB:  alu_s = op2_s - bus.id_a;
            ALU_AND:  alu_s = bus.id_a & op2_s;
            ALU_OR:   alu_s = bus.id_a | op2_s;
            ALU_XOR:  alu_s = bus.id_a ^ op2_s;
            ALU_ANDN: alu_s = bus.id_a & ~op2_s;
            ALU_SLL:  alu_s = bus.id_a << sh_s;
            ALU_SRL:  alu_s = bus.id_a >> sh_s;
            ALU_SRA:  alu_s = $unsigned($signed(bus.id_a) >>> sh_s);
            ALU_ROL:  alu_s = (bus.id_a << sh_s) | (bus.id_a >> inv_sh_s);
            ALU_ROR:  alu_s = (bus.id_a >> sh_s) | (bus.id_a << inv_sh_s);
            ALU_SEQ:  alu_s = {{(DATA_W-1){1'b0}}, (bus.id_a == op2_s)};
            ALU_SLT:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(bus.id_a) < $signed(op2_s))};
            ALU_SLE:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(bus.id_a) <= $signed(op2_s))};
            ALU_PASS: alu_s = op2_s;
            default:  alu_s = '0;
        endcase
    end

    // Branch condition, jump priority and redirect target
    always_comb begin
        taken_s = 1'b0;
        case (bus.id_br_cond)
            BR_EQZ:  taken_s = (bus.id_a == '0);
            BR_NEZ:  taken_s = (bus.id_a != '0);
            BR_LTZ:  taken_s = bus.id_a[DATA_W-1];
            BR_GEZ:  taken_s = ~bus.id_a[DATA_W-1];
            default: taken_s = 1'b0;
        endcase
        jump_s   = is_jump(bus.id_jmp_kind);
        redir_s  = jump_s | taken_s;
        target_s = ((bus.id_jmp_kind == JMP_REG) ? bus.id_a : bus.id_pc_next) + bus.id_imm;
        result_s = jump_s ? bus.id_pc_next : alu_s;
        is_mul_s = (bus.id_alu_op == ALU_MUL) & ~jump_s;
    end

    assign hold_s       = ex_valid_r & ~bus.mem_ready;
    assign bus.id_ready = ~mul_busy_s & ~bus.flush & ~hold_s;
    assign accept_s     = bus.id_valid & bus.id_ready;

    execute_stage_pipe_mult #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.flush),
        .start   (accept_s & is_mul_s),
        .hold    (hold_s),
        .a       (bus.id_a),
        .b       (op2_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Side-band fields of an in-flight multiply, parked until its product lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_store_r  <= '0;
            pend_wr_en_r  <= 1'b0;
            pend_wr_reg_r <= '0;
        end else if (accept_s & is_mul_s) begin
            pend_store_r  <= bus.id_b;
            pend_wr_en_r  <= bus.id_wr_en;
            pend_wr_reg_r <= bus.id_wr_reg;
        end
    end

    // EX/MEM output latch; accept never coincides with hold, so a held entry is never overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r    <= 1'b0;
            ex_result_r   <= '0;
            ex_store_r    <= '0;
            ex_wr_en_r    <= 1'b0;
            ex_wr_reg_r   <= '0;
            ex_redirect_r <= 1'b0;
            ex_target_r   <= '0;
        end else if (bus.flush) begin
            ex_valid_r    <= 1'b0;
            ex_redirect_r <= 1'b0;
        end else begin
            ex_redirect_r <= accept_s & redir_s;
            if (accept_s & redir_s) ex_target_r <= target_s;
            if (mul_done_s) begin
                ex_valid_r  <= 1'b1;
                ex_result_r <= product_s;
                ex_store_r  <= pend_store_r;
                ex_wr_en_r  <= pend_wr_en_r;
                ex_wr_reg_r <= pend_wr_reg_r;
            end else if (accept_s & ~is_mul_s) begin
                ex_valid_r  <= 1'b1;
                ex_result_r <= result_s;
                ex_store_r  <= bus.id_b;
                ex_wr_en_r  <= bus.id_wr_en;
                ex_wr_reg_r <= bus.id_wr_reg;
            end else if (~hold_s) begin
                ex_valid_r  <= 1'b0;
            end
        end
    end

    assign bus.ex_valid    = ex_valid_r;
    assign bus.ex_result   = ex_result_r;
    assign bus.ex_store    = ex_store_r;
    assign bus.ex_wr_en    = ex_wr_en_r;
    assign bus.ex_wr_reg   = ex_wr_reg_r;
    assign bus.ex_redirect = ex_redirect_r;
    assign bus.ex_target   = ex_target_r;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed and randomized checks of execute_stage_pipe against an arithmetic reference model.
module tb_execute_stage_pipe;
    import execute_stage_pipe_pkg::*;

    localparam int DW = 16;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_pipe_if #(.DATA_W(DW), .REG_W(RW)) bus ();
    execute_stage_pipe #(.DATA_W(DW), .REG_W(RW), .MUL_STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] st;
        logic        we;
        logic [2:0]  wr;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] a, input int sh);
        int v;
        v = int'(a) * (1 << sh);
        return 16'((v % 65536) + (v / 65536));
    endfunction

    function automatic logic [15:0] m_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] pcn,
                                             input logic [1:0] jk);
        int sh, p2, sa, sb;
        if (jk == 2'd1 || jk == 2'd2) return pcn;
        sh = int'(b % 16'd16);
        p2 = 1 << sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0:  return 16'(int'(a) + int'(b));
            4'd1:  return 16'(int'(b) - int'(a));
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a & ~b;
            4'd6:  return 16'(int'(a) * p2);
            4'd7:  return 16'(int'(a) / p2);
            4'd8:  return (sa >= 0) ? 16'(sa / p2) : 16'(-(((-sa) + p2 - 1) / p2));
            4'd9:  return rotl(a, sh);
            4'd10: return rotl(a, (16 - sh) % 16);
            4'd11: return (sa == sb) ? 16'd1 : 16'd0;
            4'd12: return (sa <  sb) ? 16'd1 : 16'd0;
            4'd13: return (sa <= sb) ? 16'd1 : 16'd0;
            4'd14: return b;
            default: return 16'(longint'(a) * longint'(b));
        endcase
    endfunction

    function automatic logic m_redir(input logic [2:0] br, input logic [1:0] jk, input logic [15:0] a);
        if (jk == 2'd1 || jk == 2'd2) return 1'b1;
        case (br)
            3'd1: return a == 16'd0;
            3'd2: return a != 16'd0;
            3'd3: return a >= 16'h8000;
            3'd4: return a <  16'h8000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] m_target(input logic [1:0] jk, input logic [15:0] a,
                                             input logic [15:0] pcn, input logic [15:0] imm);
        return 16'(int'((jk == 2'd2) ? a : pcn) + int'(imm));
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] imm, input logic [15:0] pcn, input logic src,
                         input logic [2:0] br, input logic [1:0] jk, input logic we,
                         input logic [2:0] wr);
        bus.id_alu_op   = op;
        bus.id_a        = a;
        bus.id_b        = b;
        bus.id_imm      = imm;
        bus.id_pc_next  = pcn;
        bus.id_src_imm  = src;
        bus.id_br_cond  = br;
        bus.id_jmp_kind = jk;
        bus.id_wr_en    = we;
        bus.id_wr_reg   = wr;
        bus.id_valid    = 1'b1;
    endtask

    int          low, issued;
    logic        got, stale, hs, exp_redir;
    logic [15:0] exp_tgt, op2;
    ent_t        e;

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b1;
        drive(4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
        bus.id_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_result", bus.ex_result, 0);
        chk("rst_target", bus.ex_target, 0);
        chk("rst_redirect", bus.ex_redirect, 0);
        chk("rst_wr_en", bus.ex_wr_en, 0);
        rst = 1'b0;

        // single-cycle ADD
        @(negedge clk);
        drive(ALU_ADD, 16'h0003, 16'h0000, 16'h0005, 16'h0000, 1'b1, BR_NONE, JMP_NONE, 1'b1, 3'd3);
        #1 chk("add_ready", bus.id_ready, 1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        chk("add_valid", bus.ex_valid, 1);
        chk("add_result", bus.ex_result, 16'h0008);
        chk("add_wr_reg", bus.ex_wr_reg, 3);
        chk("add_wr_en", bus.ex_wr_en, 1);

        // multi-cycle MUL
        @(negedge clk);
        drive(ALU_MUL, 16'h0007, 16'h0009, 16'h0000, 16'h0000, 1'b0, BR_NONE, JMP_NONE, 1'b1, 3'd5);
        #1 chk("mul_ready", bus.id_ready, 1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        #1;
        got = 1'b0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (!got) begin
                if (bus.ex_valid) got = 1'b1;
                else begin
                    if (!bus.id_ready) low++;
                    @(negedge clk);
                end
            end
        end
        chk("mul_done_seen", got, 1);
        chk("mul_ready_low", low, 17);
        chk("mul_result", bus.ex_result, 16'h003F);
        chk("mul_wr_reg", bus.ex_wr_reg, 5);

        // taken and not-taken branch
        @(negedge clk);
        drive(ALU_PASS, 16'h0000, 16'h0000, 16'hFFFC, 16'h0010, 1'b1, BR_EQZ, JMP_NONE, 1'b0, 3'd0);
        @(negedge clk);
        bus.id_valid = 1'b0;
        chk("br_redirect", bus.ex_redirect, 1);
        chk("br_target", bus.ex_target, 16'h000C);
        @(negedge clk);
        chk("br_pulse_end", bus.ex_redirect, 0);
        drive(ALU_PASS, 16'h0001, 16'h0000, 16'hFFFC, 16'h0010, 1'b1, BR_EQZ, JMP_NONE, 1'b0, 3'd0);
        @(negedge clk);
        bus.id_valid = 1'b0;
        chk("nt_redirect", bus.ex_redirect, 0);
        chk("nt_target", bus.ex_target, 16'h000C);

        // back-pressure hold
        @(negedge clk);
        drive(ALU_ADD, 16'h0010, 16'h0000, 16'h0020, 16'h0000, 1'b1, BR_NONE, JMP_NONE, 1'b1, 3'd2);
        @(negedge clk);
        chk("hold_first", bus.ex_result, 16'h0030);
        bus.mem_ready = 1'b0;
        drive(ALU_SUB, 16'h0001, 16'h000A, 16'h0000, 16'h0000, 1'b0, BR_NONE, JMP_NONE, 1'b1, 3'd6);
        #1 chk("hold_ready", bus.id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.ex_valid, 1);
            chk("hold_result", bus.ex_result, 16'h0030);
            chk("hold_wr_reg", bus.ex_wr_reg, 2);
            chk("hold_id_ready", bus.id_ready, 0);
        end
        bus.mem_ready = 1'b1;
        #1 chk("rel_ready", bus.id_ready, 1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        chk("rel_valid", bus.ex_valid, 1);
        chk("rel_result", bus.ex_result, 16'h0009);
        chk("rel_wr_reg", bus.ex_wr_reg, 6);

        // flush during BUSY cycle 5
        @(negedge clk);
        drive(ALU_MUL, 16'h1234, 16'h0003, 16'h0000, 16'h0000, 1'b0, BR_NONE, JMP_NONE, 1'b1, 3'd1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        #1 chk("fl_ready", bus.id_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1 chk("fl_ready_after", bus.id_ready, 1);
        chk("fl_valid", bus.ex_valid, 0);
        stale = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            stale = stale | bus.ex_valid;
        end
        chk("fl_no_stale", stale, 0);

        // asynchronous reset mid-multiply, then register jump
        drive(ALU_MUL, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1'b0, BR_NONE, JMP_NONE, 1'b1, 3'd4);
        @(negedge clk);
        bus.id_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_target", bus.ex_target, 0);
        chk("arst_valid", bus.ex_valid, 0);
        chk("arst_ready", bus.id_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(ALU_ADD, 16'h8000, 16'h0000, 16'h8002, 16'h0040, 1'b1, BR_NONE, JMP_REG, 1'b1, 3'd7);
        #1 chk("jr_ready", bus.id_ready, 1);
        @(negedge clk);
        bus.id_valid = 1'b0;
        chk("jr_redirect", bus.ex_redirect, 1);
        chk("jr_target", bus.ex_target, 16'h0002);
        chk("jr_result", bus.ex_result, 16'h0040);
        chk("jr_valid", bus.ex_valid, 1);
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stale = stale | bus.ex_valid;
        end
        chk("arst_no_stale", stale, 0);

        // randomized traffic against the scoreboard
        issued = 0;
        hs = 1'b0;
        exp_redir = 1'b0;
        exp_tgt = 16'h0002;
        for (int cyc = 0; cyc < 8000 && (issued < 150 || q.size() != 0 || bus.id_valid); cyc++) begin
            @(negedge clk);
            chk("rnd_redirect", bus.ex_redirect, exp_redir);
            chk("rnd_target", bus.ex_target, exp_tgt);
            if (hs) bus.id_valid = 1'b0;
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            if (bus.ex_valid && bus.mem_ready) begin
                if (q.size() == 0) chk("rnd_unexpected", bus.ex_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_result", bus.ex_result, e.res);
                    chk("rnd_store", bus.ex_store, e.st);
                    chk("rnd_wr_en", bus.ex_wr_en, e.we);
                    chk("rnd_wr_reg", bus.ex_wr_reg, e.wr);
                end
            end
            if (!bus.id_valid && issued < 150 && $urandom_range(0, 1) == 1) begin
                drive(4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0,
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
                if (bus.id_alu_op == 4'd15 && $urandom_range(0, 3) != 0) bus.id_alu_op = 4'd0;
            end
            #1;
            exp_redir = 1'b0;
            hs = bus.id_valid && bus.id_ready;
            if (hs) begin
                op2 = bus.id_src_imm ? bus.id_imm : bus.id_b;
                q.push_back('{res: m_result(bus.id_alu_op, bus.id_a, op2, bus.id_pc_next, bus.id_jmp_kind),
                              st: bus.id_b, we: bus.id_wr_en, wr: bus.id_wr_reg});
                if (m_redir(bus.id_br_cond, bus.id_jmp_kind, bus.id_a)) begin
                    exp_redir = 1'b1;
                    exp_tgt = m_target(bus.id_jmp_kind, bus.id_a, bus.id_pc_next, bus.id_imm);
                end
                issued++;
            end
        end
        chk("rnd_issued", issued, 150);
        chk("rnd_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
